// File: rtl/mem_responder.sv
// mem_responder: byte-wide memory responder for a simple CPU memory controller.
// Serves a RAM region plus a small IO window (UART TX FIFO, UART RX holding
// register, program-end flag). Every result is registered, and all state is
// frozen while rdy is low.
module mem_responder #(
    parameter int RAM_ADDR_WID = 17,
    parameter int TXQ_LOG      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        sim_halt,
    output logic        tx_overflow
);

    localparam int RAM_DEPTH = 1 << RAM_ADDR_WID;
    localparam int TXQ_DEPTH = 1 << TXQ_LOG;

    localparam logic [TXQ_LOG-1:0] PTR_ONE  = {{(TXQ_LOG-1){1'b0}}, 1'b1};
    localparam logic [TXQ_LOG:0]   CNT_ZERO = {(TXQ_LOG+1){1'b0}};
    localparam logic [TXQ_LOG:0]   CNT_ONE  = {{TXQ_LOG{1'b0}}, 1'b1};
    localparam logic [TXQ_LOG:0]   FULL_CNT = {1'b1, {TXQ_LOG{1'b0}}};
    // Two slots of margin: the controller checks the flag a cycle before it writes.
    localparam logic [TXQ_LOG:0]   NEAR_CNT = FULL_CNT - {{(TXQ_LOG-1){1'b0}}, 2'b10};

    // Storage
    logic [7:0]              ram_r  [0:RAM_DEPTH-1];
    logic [7:0]              fifo_r [0:TXQ_DEPTH-1];

    // FIFO bookkeeping
    logic [TXQ_LOG-1:0]      wr_ptr_r;
    logic [TXQ_LOG-1:0]      rd_ptr_r;
    logic [TXQ_LOG:0]        count_r;
    logic [TXQ_LOG-1:0]      wr_ptr_next_s;
    logic [TXQ_LOG-1:0]      rd_ptr_next_s;
    logic [TXQ_LOG:0]        count_next_s;
    logic [7:0]              head_next_s;

    // RX holding register
    logic                    rx_has_r;
    logic [7:0]              rx_byte_r;

    // Decode
    logic                    is_io_s;
    logic [2:0]              io_off_s;
    logic [RAM_ADDR_WID-1:0] ram_idx_s;
    logic                    push_req_s;
    logic                    push_ok_s;
    logic                    push_drop_s;
    logic                    pop_s;
    logic                    rx_clear_s;
    logic                    halt_set_s;
    logic [7:0]              io_rdata_s;
    logic                    unused_addr_s;

    // Upper address bits do not take part in the decode.
    assign unused_addr_s = ^mem_a;

    // Address decode, FIFO next-state and IO read-data selection
    always_comb begin
        is_io_s       = (mem_a[17:16] == 2'b11);
        io_off_s      = mem_a[2:0];
        ram_idx_s     = mem_a[RAM_ADDR_WID-1:0];
        push_req_s    = is_io_s && mem_wr && (io_off_s == 3'd0);
        halt_set_s    = is_io_s && mem_wr && (io_off_s == 3'd4);
        rx_clear_s    = is_io_s && !mem_wr && (io_off_s == 3'd0);
        pop_s         = tx_valid && tx_ready;
        push_ok_s     = 1'b0;
        push_drop_s   = 1'b0;
        count_next_s  = count_r;
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        head_next_s   = 8'h00;
        io_rdata_s    = 8'h00;

        // A full FIFO can still take a push when a byte leaves in the same cycle.
        if (push_req_s) begin
            if ((count_r == FULL_CNT) && !pop_s) begin
                push_drop_s = 1'b1;
            end else begin
                push_ok_s = 1'b1;
            end
        end else begin
            push_ok_s   = 1'b0;
            push_drop_s = 1'b0;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase

        if (push_ok_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        // The new head is the byte being written when it lands in the head slot
        // (FIFO empty, or its single byte popped this cycle).
        if (count_next_s == CNT_ZERO) begin
            head_next_s = 8'h00;
        end else if (push_ok_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = mem_dout;
        end else begin
            head_next_s = fifo_r[rd_ptr_next_s];
        end

        case (io_off_s)
            3'd0:    io_rdata_s = rx_has_r ? rx_byte_r : 8'h00;
            3'd4:    io_rdata_s = {6'b000000, rx_has_r, io_buffer_full};
            default: io_rdata_s = 8'h00;
        endcase
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && rdy && mem_wr && !is_io_s) begin
            ram_r[ram_idx_s] <= mem_dout;
        end
    end

    // TX FIFO storage write
    always_ff @(posedge clk) begin
        if (!rst && rdy && push_ok_s) begin
            fifo_r[wr_ptr_r] <= mem_dout;
        end
    end

    // Control state, read data, RX holding register and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_din        <= 8'h00;
            io_buffer_full <= 1'b0;
            tx_valid       <= 1'b0;
            tx_data        <= 8'h00;
            sim_halt       <= 1'b0;
            tx_overflow    <= 1'b0;
            rx_has_r       <= 1'b0;
            rx_byte_r      <= 8'h00;
            wr_ptr_r       <= {TXQ_LOG{1'b0}};
            rd_ptr_r       <= {TXQ_LOG{1'b0}};
            count_r        <= CNT_ZERO;
        end else if (rdy) begin
            if (!mem_wr) begin
                mem_din <= is_io_s ? io_rdata_s : ram_r[ram_idx_s];
            end
            wr_ptr_r       <= wr_ptr_next_s;
            rd_ptr_r       <= rd_ptr_next_s;
            count_r        <= count_next_s;
            tx_valid       <= (count_next_s != CNT_ZERO);
            tx_data        <= head_next_s;
            io_buffer_full <= (count_next_s >= NEAR_CNT);
            sim_halt       <= sim_halt | halt_set_s;
            tx_overflow    <= tx_overflow | push_drop_s;
            // A fresh byte wins over a same-cycle read-clear.
            if (rx_valid) begin
                rx_byte_r <= rx_data;
                rx_has_r  <= 1'b1;
            end else if (rx_clear_s) begin
                rx_has_r  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder. The driver applies
// stimulus and updates a queue/array reference model; a monitor pops expected
// read data and TX bytes whenever the DUT presents them.
module tb_mem_responder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        sim_halt;
    logic        tx_overflow;

    mem_responder #(.RAM_ADDR_WID(17), .TXQ_LOG(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_a(mem_a), .mem_dout(mem_dout),
        .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .sim_halt(sim_halt),
        .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_ram [int];
    logic [7:0] m_fifo [$];
    logic [7:0] exp_tx_q [$];
    logic [7:0] exp_rd_q [$];
    logic       m_rxhas = 1'b0;
    logic [7:0] m_rxbyte = 8'h00;
    logic       m_halt = 1'b0;
    logic       m_ovf = 1'b0;
    logic       drv_armed = 1'b0;
    logic       prev_rst = 1'b0;

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endfunction

    // One bus cycle: check flags left by the previous edge, drive, update model.
    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d,
                        input logic tr, input logic rv, input logic [7:0] rb, input logic rs);
        logic       io;
        logic [2:0] off;
        logic       pop;
        logic [7:0] rexp;
        @(negedge clk);
        if (drv_armed) begin
            chk("tx_valid", {7'b0, tx_valid}, {7'b0, (m_fifo.size() > 0)});
            chk("io_buffer_full", {7'b0, io_buffer_full}, {7'b0, (m_fifo.size() >= DEPTH - 2)});
            chk("tx_overflow", {7'b0, tx_overflow}, {7'b0, m_ovf});
            chk("sim_halt", {7'b0, sim_halt}, {7'b0, m_halt});
            if (prev_rst) chk("tx_data_rst", tx_data, 8'h00);
        end
        rdy = r; mem_wr = w; mem_a = a; mem_dout = d;
        tx_ready = tr; rx_valid = rv; rx_data = rb; rst = rs;
        prev_rst = rs;
        if (rs) drv_armed = 1'b1;
        io  = (a[17:16] == 2'b11);
        off = a[2:0];
        if (rs) begin
            m_fifo.delete(); exp_tx_q.delete();
            m_rxhas = 1'b0; m_halt = 1'b0; m_ovf = 1'b0;
        end else if (r) begin
            if (!w) begin
                if (io) begin
                    if (off == 3'd0)      rexp = m_rxhas ? m_rxbyte : 8'h00;
                    else if (off == 3'd4) rexp = {6'b0, m_rxhas, (m_fifo.size() >= DEPTH - 2)};
                    else                  rexp = 8'h00;
                end else begin
                    rexp = m_ram.exists(int'(a[16:0])) ? m_ram[int'(a[16:0])] : 8'hxx;
                end
                exp_rd_q.push_back(rexp);
            end
            pop = (m_fifo.size() > 0) && tr;
            if (pop) void'(m_fifo.pop_front());
            if (w && io && off == 3'd0) begin
                if (m_fifo.size() == DEPTH) m_ovf = 1'b1;
                else begin m_fifo.push_back(d); exp_tx_q.push_back(d); end
            end
            if (w && io && off == 3'd4) m_halt = 1'b1;
            if (w && !io) m_ram[int'(a[16:0])] = d;
            if (rv) begin m_rxhas = 1'b1; m_rxbyte = rb; end
            else if (!w && io && off == 3'd0) m_rxhas = 1'b0;
        end
    endtask

    task automatic idle(input logic tr, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 32'h0003_0002, 8'h00, tr, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic push(input logic [7:0] d, input logic tr);
        step(1'b1, 1'b1, 32'h0003_0000, d, tr, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Monitor: read data after each edge, and TX bytes on every handshake.
    logic       mon_armed = 1'b0;
    logic       p_rst = 1'b0;
    logic       p_rd = 1'b0;
    logic [7:0] last_din = 8'h00;
    always @(negedge clk) begin
        #1;
        if (mon_armed) begin
            if (p_rst) chk("din_after_rst", mem_din, 8'h00);
            else if (p_rd) begin
                if (exp_rd_q.size() == 0) chk("din_unexpected_read", 8'hEE, 8'h00);
                else chk("din_read", mem_din, exp_rd_q.pop_front());
            end else chk("din_hold", mem_din, last_din);
        end
        last_din = mem_din;
        p_rst = rst;
        p_rd  = !rst && rdy && !mem_wr;
        if (rst) mon_armed = 1'b1;
        if (mon_armed && !rst && rdy && tx_valid && tx_ready) begin
            if (exp_tx_q.size() == 0) chk("tx_unexpected_byte", tx_data, 8'hEE);
            else chk("tx_byte", tx_data, exp_tx_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] up;
        logic [31:0] a;
        logic [7:0]  v;
        int          k;
        rst = 1'b1; rdy = 1'b0; mem_wr = 1'b0; mem_a = 32'h0; mem_dout = 8'h00;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

        // Reset with a read in flight
        step(1'b1, 1'b0, 32'h0000_0100, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 32'h0000_0100, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

        // RAM streaming
        for (int i = 0; i < 4; i++) begin
            v = 8'((i + 1) * 17);
            step(1'b1, 1'b1, 32'h100 + 32'(i), v, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < 4; i++) rd(32'h100 + 32'(i));
        idle(1'b0, 2);

        // RX holding register
        step(1'b1, 1'b1, 32'h0003_0002, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0);
        rd(32'h0003_0004); rd(32'h0003_0000); rd(32'h0003_0000); rd(32'h0003_0004);
        // rx_valid alongside an offset-0 read keeps the byte pending
        step(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b0);
        step(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0);
        rd(32'h0003_0004); rd(32'h0003_0000);
        idle(1'b0, 1);

        // Halt with rdy gating
        step(1'b0, 1'b1, 32'h0003_0004, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0);
        idle(1'b0, 1);
        step(1'b1, 1'b1, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(1'b0, 2);

        // TX fill, near-full, overflow, drain
        for (int i = 0; i < 17; i++) push(8'(8'hA0 + i), 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 20);

        // Simultaneous push and pop at count 5
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 10; i++) push(8'(8'h50 + i), 1'b1);
        idle(1'b1, 8);

        // Mid-stream reset keeps RAM
        for (int i = 0; i < 6; i++) push(8'(8'hD0 + i), 1'b0);
        step(1'b1, 1'b0, 32'h0000_0100, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        rd(32'h0000_0100);
        idle(1'b0, 2);

        // Randomized traffic
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 32'h200 + 32'(i), 8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);
        for (int n = 0; n < 500; n++) begin
            up = $urandom();
            k  = int'($urandom_range(0, 9));
            if (k < 4) begin
                a = ($urandom_range(0, 3) == 0) ? 32'h100 + 32'($urandom_range(0, 3))
                                                : 32'h200 + 32'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 0) a[17] = 1'b1;
            end else begin
                a = 32'h0003_0000 + 32'($urandom_range(0, 7));
                if ($urandom_range(0, 2) != 0) a[2:0] = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'd0;
            end
            a[31:18] = up[31:18];
            step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, a, 8'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0, 8'($urandom),
                 $urandom_range(0, 149) == 0);
        end

        idle(1'b1, 25);
        chk("rd_queue_empty", 8'(exp_rd_q.size()), 8'h00);
        chk("tx_queue_empty", 8'(exp_tx_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
